// File: rtl/sonar_pkg.sv
// Shared sonar receive-path types and default constants, also used by the velocity logic.
package sonar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_LISTEN = 2'd2
  } state_e;

  localparam int unsigned SAMPLE_WIDTH_DEF    = 16;
  localparam int unsigned TIME_WIDTH_DEF      = 32;
  localparam int unsigned THRESH_HI_DEF       = 5000;
  localparam int unsigned THRESH_LO_DEF       = 3000;
  localparam int unsigned CONFIRM_SAMPLES_DEF = 4;

endpackage

// File: rtl/hysteresis_run_counter.sv
// Sample magnitude, hysteresis thresholds, qualifying-run counter and echo onset latch.
module hysteresis_run_counter
  import sonar_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH    = SAMPLE_WIDTH_DEF,
  parameter int unsigned TIME_WIDTH      = TIME_WIDTH_DEF,
  parameter int unsigned THRESH_HI       = THRESH_HI_DEF,
  parameter int unsigned THRESH_LO       = THRESH_LO_DEF,
  parameter int unsigned CONFIRM_SAMPLES = CONFIRM_SAMPLES_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           valid_i,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
  input  logic [TIME_WIDTH-1:0]          counter_i,
  output logic                           confirm_o,
  output logic [TIME_WIDTH-1:0]          onset_o,
  output logic                           above_o
);

  localparam int unsigned RUN_W = $clog2(CONFIRM_SAMPLES + 1);
  localparam logic [SAMPLE_WIDTH-1:0] HI      = SAMPLE_WIDTH'(THRESH_HI);
  localparam logic [SAMPLE_WIDTH-1:0] LO      = SAMPLE_WIDTH'(THRESH_LO);
  localparam logic [SAMPLE_WIDTH-1:0] MAG_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic [SAMPLE_WIDTH-1:0] NEG_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
  localparam logic [RUN_W-1:0]        RUN_TARGET = RUN_W'(CONFIRM_SAMPLES);

  logic [SAMPLE_WIDTH-1:0] raw;
  logic [SAMPLE_WIDTH-1:0] mag;
  logic                    hi;
  logic                    lo;
  logic [RUN_W-1:0]        run_q, run_d, run_inc;
  logic [TIME_WIDTH-1:0]   onset_q, onset_d;
  logic                    above_q, above_d;

  always_comb begin
    raw = sample_i;
    if (raw == NEG_MIN) begin
      mag = MAG_MAX;
    end else if (raw[SAMPLE_WIDTH-1]) begin
      mag = '0 - raw;
    end else begin
      mag = raw;
    end
    hi = (mag >= HI);
    lo = (mag < LO);
  end

  // Onset reported with a confirmation is the current counter when the run starts this cycle.
  always_comb begin
    run_inc   = run_q + 1'b1;
    run_d     = run_q;
    onset_d   = onset_q;
    above_d   = valid_i ? hi : above_q;
    confirm_o = !clear_i && valid_i && hi && (run_inc == RUN_TARGET);
    onset_o   = (run_q == '0) ? counter_i : onset_q;
    if (clear_i) begin
      run_d = '0;
    end else if (valid_i) begin
      if (hi) begin
        run_d = run_inc;
        if (run_q == '0) begin
          onset_d = counter_i;
        end
      end else if (lo) begin
        run_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q   <= '0;
      onset_q <= '0;
      above_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      onset_q <= onset_d;
      above_q <= above_d;
    end
  end

  assign above_o = above_q;

endmodule

// File: rtl/echo_arrival_detector.sv
// Receive-window FSM: blanking, listening window, echo time-of-flight report or timeout.
module echo_arrival_detector
  import sonar_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH    = SAMPLE_WIDTH_DEF,
  parameter int unsigned TIME_WIDTH      = TIME_WIDTH_DEF,
  parameter int unsigned BLANK_CYCLES    = 100000,
  parameter int unsigned TIMEOUT_CYCLES  = 5000000,
  parameter int unsigned THRESH_HI       = THRESH_HI_DEF,
  parameter int unsigned THRESH_LO       = THRESH_LO_DEF,
  parameter int unsigned CONFIRM_SAMPLES = CONFIRM_SAMPLES_DEF
) (
  input  logic                           clk_in,
  input  logic                           rst_n,
  input  logic                           burst_start_in,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                           sample_valid_in,
  output logic                           echo_valid_out,
  output logic [TIME_WIDTH-1:0]          echo_time_out,
  output logic                           timeout_out,
  output logic                           busy_out,
  output logic                           above_thresh_out
);

  localparam logic [TIME_WIDTH-1:0] BLANK_LAST   = TIME_WIDTH'(BLANK_CYCLES - 1);
  localparam logic [TIME_WIDTH-1:0] TIMEOUT_LAST = TIME_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [TIME_WIDTH-1:0] counter_q, counter_d, counter_inc;
  logic                  echo_valid_q, echo_valid_d;
  logic [TIME_WIDTH-1:0] echo_time_q, echo_time_d;
  logic                  timeout_q, timeout_d;
  logic                  run_clear;
  logic                  confirm;
  logic [TIME_WIDTH-1:0] onset;

  // Run is held cleared outside LISTEN, so confirmation is implicitly gated by state and burst.
  assign run_clear = burst_start_in || (state_q != ST_LISTEN);

  hysteresis_run_counter #(
    .SAMPLE_WIDTH    (SAMPLE_WIDTH),
    .TIME_WIDTH      (TIME_WIDTH),
    .THRESH_HI       (THRESH_HI),
    .THRESH_LO       (THRESH_LO),
    .CONFIRM_SAMPLES (CONFIRM_SAMPLES)
  ) u_run (
    .clk_i     (clk_in),
    .rst_ni    (rst_n),
    .clear_i   (run_clear),
    .valid_i   (sample_valid_in),
    .sample_i  (sample_in),
    .counter_i (counter_q),
    .confirm_o (confirm),
    .onset_o   (onset),
    .above_o   (above_thresh_out)
  );

  always_comb begin
    counter_inc  = (counter_q == '1) ? counter_q : counter_q + 1'b1;
    state_d      = state_q;
    counter_d    = counter_q;
    echo_valid_d = 1'b0;
    echo_time_d  = echo_time_q;
    timeout_d    = 1'b0;
    if (burst_start_in) begin
      state_d   = ST_BLANK;
      counter_d = '0;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          counter_d = counter_inc;
          if (counter_q == TIMEOUT_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (counter_q == BLANK_LAST) begin
            state_d = ST_LISTEN;
          end
        end
        ST_LISTEN: begin
          counter_d = counter_inc;
          if (confirm) begin
            echo_valid_d = 1'b1;
            echo_time_d  = onset;
            state_d      = ST_IDLE;
          end else if (counter_q == TIMEOUT_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      counter_q    <= '0;
      echo_valid_q <= 1'b0;
      echo_time_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      echo_valid_q <= echo_valid_d;
      echo_time_q  <= echo_time_d;
      timeout_q    <= timeout_d;
    end
  end

  assign echo_valid_out = echo_valid_q;
  assign echo_time_out  = echo_time_q;
  assign timeout_out    = timeout_q;
  assign busy_out       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_echo_arrival_detector.sv
// Self-checking bench for echo_arrival_detector: directed table, corner sequences, random bursts.
module tb_echo_arrival_detector;

  localparam int BLANK = 10;
  localparam int TMO   = 1000;
  localparam int HI    = 5000;
  localparam int LO    = 3000;
  localparam int NCONF = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               burst;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               echo_valid_out;
  logic [31:0]        echo_time_out;
  logic               timeout_out;
  logic               busy_out;
  logic               above_thresh_out;

  always #5 clk = ~clk;

  echo_arrival_detector #(
    .SAMPLE_WIDTH    (16),
    .TIME_WIDTH      (32),
    .BLANK_CYCLES    (BLANK),
    .TIMEOUT_CYCLES  (TMO),
    .THRESH_HI       (HI),
    .THRESH_LO       (LO),
    .CONFIRM_SAMPLES (NCONF)
  ) dut (
    .clk_in           (clk),
    .rst_n            (rst_n),
    .burst_start_in   (burst),
    .sample_in        (sample),
    .sample_valid_in  (sample_valid),
    .echo_valid_out   (echo_valid_out),
    .echo_time_out    (echo_time_out),
    .timeout_out      (timeout_out),
    .busy_out         (busy_out),
    .above_thresh_out (above_thresh_out)
  );

  typedef struct {
    int start;
    int n;
    int echo;
    int onset;
    int endc;
  } vec_t;

  vec_t tbl[11];
  int   tbl_s[11][8];

  int checks = 0;
  int errors = 0;
  int smp[1024];
  bit vld[1024];
  int exp_etime = 0;
  bit exp_above = 1'b0;

  task automatic chk(input string what, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @k=%0d: got %0d, expected %0d", what, k, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int k, input bit ev, input bit to, input bit busy);
    chk({tag, ".echo_valid"}, k, 32'(echo_valid_out), 32'(ev));
    chk({tag, ".timeout"}, k, 32'(timeout_out), 32'(to));
    chk({tag, ".busy"}, k, 32'(busy_out), 32'(busy));
    chk({tag, ".echo_time"}, k, echo_time_out, 32'(exp_etime));
    chk({tag, ".above"}, k, 32'(above_thresh_out), 32'(exp_above));
  endtask

  function automatic int mag(input int v);
    int m;
    m = (v < 0) ? -v : v;
    return (m > 32767) ? 32767 : m;
  endfunction

  // Scans the whole trace of one burst and predicts how it ends.
  function automatic void ref_outcome(output int is_echo, output int onset, output int endc);
    int run;
    int on;
    run     = 0;
    on      = 0;
    is_echo = 0;
    onset   = 0;
    endc    = TMO - 1;
    for (int c = BLANK; c < TMO; c++) begin
      if (vld[c]) begin
        if (mag(smp[c]) >= HI) begin
          if (run == 0) on = c;
          run++;
          if (run == NCONF) begin
            is_echo = 1;
            onset   = on;
            endc    = c;
            return;
          end
        end else if (mag(smp[c]) < LO) begin
          run = 0;
        end
      end
    end
  endfunction

  task automatic drive_cycle(input int v, input bit valid);
    sample       = 16'(v);
    sample_valid = valid;
    @(posedge clk);
    #1;
    if (valid) exp_above = (mag(v) >= HI);
  endtask

  task automatic pulse_burst(input string tag);
    burst        = 1'b1;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    burst = 1'b0;
    check_all(tag, -1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic clear_trace();
    for (int i = 0; i < 1024; i++) begin
      smp[i] = 0;
      vld[i] = 1'b1;
    end
  endtask

  // Drives samples for counters 0.. and checks the outputs after each edge.
  task automatic run_trace(input string tag, input int is_echo, input int onset, input int endc, input int last_k);
    for (int k = 0; k <= endc + 2 && k <= last_k; k++) begin
      drive_cycle(smp[k], vld[k]);
      if (is_echo != 0 && k == endc) exp_etime = onset;
      check_all(tag, k, is_echo != 0 && k == endc, is_echo == 0 && k == endc, k < endc);
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r_echo;
    int r_onset;
    int r_end;

    tbl[0]  = '{50, 3, 1, 50, 52};   tbl_s[0]  = '{6000, 6000, 6000, 0, 0, 0, 0, 0};
    tbl[1]  = '{100, 4, 1, 100, 103}; tbl_s[1]  = '{6000, 6000, 4000, -6000, 0, 0, 0, 0};
    tbl[2]  = '{100, 6, 1, 103, 105}; tbl_s[2]  = '{6000, 6000, 2000, -6000, 6000, 6000, 0, 0};
    tbl[3]  = '{2, 7, 0, 0, 999};     tbl_s[3]  = '{8000, 8000, 8000, 8000, 8000, 8000, 8000, 0};
    tbl[4]  = '{20, 3, 1, 20, 22};    tbl_s[4]  = '{-32768, -32768, -32768, 0, 0, 0, 0, 0};
    tbl[5]  = '{8, 5, 1, 10, 12};     tbl_s[5]  = '{8000, 8000, 5000, 5000, 5000, 0, 0, 0};
    tbl[6]  = '{30, 6, 0, 0, 999};    tbl_s[6]  = '{4999, -4999, 4999, 4999, 4999, 4999, 0, 0};
    tbl[7]  = '{997, 3, 1, 997, 999}; tbl_s[7]  = '{6000, 6000, 6000, 0, 0, 0, 0, 0};
    tbl[8]  = '{200, 4, 1, 200, 203}; tbl_s[8]  = '{6000, 3000, 6000, 6000, 0, 0, 0, 0};
    tbl[9]  = '{200, 5, 1, 202, 204}; tbl_s[9]  = '{6000, 2999, 6000, 6000, 6000, 0, 0, 0};
    tbl[10] = '{998, 3, 0, 0, 999};   tbl_s[10] = '{6000, 6000, 6000, 0, 0, 0, 0, 0};

    rst_n        = 1'b0;
    burst        = 1'b0;
    sample       = '0;
    sample_valid = 1'b0;

    for (int i = 0; i < 6; i++) begin
      burst        = (i % 2 == 1);
      sample       = 16'sd8000;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      check_all("reset", i, 1'b0, 1'b0, 1'b0);
    end
    rst_n        = 1'b1;
    burst        = 1'b0;
    sample_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_all("idle", i, 1'b0, 1'b0, 1'b0);
    end
    drive_cycle(-9000, 1'b1);
    check_all("idle_above_hi", 0, 1'b0, 1'b0, 1'b0);
    drive_cycle(0, 1'b0);
    check_all("idle_above_hold", 1, 1'b0, 1'b0, 1'b0);
    drive_cycle(100, 1'b1);
    check_all("idle_above_lo", 2, 1'b0, 1'b0, 1'b0);
    sample_valid = 1'b0;

    for (int t = 0; t < 11; t++) begin
      clear_trace();
      for (int i = 0; i < tbl[t].n; i++) smp[tbl[t].start + i] = tbl_s[t][i];
      pulse_burst($sformatf("vec%0d", t));
      run_trace($sformatf("vec%0d", t), tbl[t].echo, tbl[t].onset, tbl[t].endc, 2000);
    end

    clear_trace();
    smp[40] = 6000;
    smp[41] = 6000;
    pulse_burst("abort_pre");
    run_trace("abort_pre", 0, 0, TMO - 1, 41);
    burst        = 1'b1;
    sample       = 16'sd6000;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    burst     = 1'b0;
    exp_above = 1'b1;
    check_all("abort_edge", -1, 1'b0, 1'b0, 1'b1);
    clear_trace();
    for (int i = 0; i <= 12; i++) smp[i] = 6000;
    run_trace("abort_post", 1, 10, 12, 2000);

    clear_trace();
    smp[58] = 7000;
    smp[59] = 7000;
    pulse_burst("arst");
    run_trace("arst", 0, 0, TMO - 1, 59);
    #3;
    rst_n = 1'b0;
    #1;
    exp_etime = 0;
    exp_above = 1'b0;
    check_all("arst_async", -1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all("arst_after", i, 1'b0, 1'b0, 1'b0);
    end

    for (int r = 0; r < 25; r++) begin
      int p;
      p = int'($urandom_range(0, 5));
      for (int c = 0; c < 1024; c++) begin
        int sel;
        int v;
        vld[c] = (($urandom % 10) != 0);
        sel    = int'($urandom % 16);
        if (sel < p) begin
          v = int'($urandom_range(5000, 32768));
        end else if (sel < p + 3) begin
          v = int'($urandom_range(2990, 5010));
        end else begin
          v = int'($urandom_range(0, 2999));
        end
        if (($urandom % 2) == 1) v = -v;
        if (v > 32767) v = 32767;
        smp[c] = v;
      end
      ref_outcome(r_echo, r_onset, r_end);
      pulse_burst("rand");
      run_trace("rand", r_echo, r_onset, r_end, 2000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/echo_arrival_detector.md
Name: echo_arrival_detector

Overview:
Receive-side counterpart of the burst transmit path. Armed by the one-cycle burst-start pulse, it times the listening window and ignores transmitter ringing during a blanking interval. It then applies a magnitude threshold with hysteresis and N-sample confirmation to the aggregated receive waveform, and reports the time of flight (cycles from burst start to echo onset) or a timeout. Its outputs feed range computation and the display path.

Parameters:
SAMPLE_WIDTH, 16, width of signed aggregated receive sample
TIME_WIDTH, 32, width of cycle counter and timestamp
BLANK_CYCLES, 100000, cycles after burst start during which samples are ignored (1 ms at 100 MHz)
TIMEOUT_CYCLES, 5000000, cycles after burst start at which listening ends with no echo
THRESH_HI, 5000, magnitude at or above which a sample counts toward confirmation
THRESH_LO, 3000, magnitude below which the confirmation run is cleared; THRESH_LO <= THRESH_HI
CONFIRM_SAMPLES, 4, qualifying samples required to declare an echo; >= 1

Ports:
clk_in  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
burst_start_in  input  1  one-cycle pulse marking start of transmit burst
sample_in  input  SAMPLE_WIDTH  signed aggregated receive sample
sample_valid_in  input  1  sample_in is valid this cycle
echo_valid_out  output  1  one-cycle pulse: echo confirmed
echo_time_out  output  TIME_WIDTH  onset cycle count of the last confirmed echo
timeout_out  output  1  one-cycle pulse: window expired without an echo
busy_out  output  1  high in BLANK or LISTEN
above_thresh_out  output  1  registered: last valid sample magnitude >= THRESH_HI, for the velocity path

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; counter, run, and onset latch 0.
- States: IDLE, BLANK, LISTEN.
- burst_start_in, sampled in any state: next state BLANK, counter = 0, run = 0. An in-progress measurement is aborted silently with no pulse. This has priority over every other event.
- Counter increments every cycle in BLANK/LISTEN. It saturates at its max and never wraps.
- BLANK: when counter == BLANK_CYCLES-1, go to LISTEN. Samples are ignored.
- Magnitude: |sample_in|; most-negative value saturates to 2^(SAMPLE_WIDTH-1)-1. Unsigned compare.
- LISTEN, on a valid sample, by magnitude:
  - mag >= THRESH_HI: run += 1. If run was 0, latch onset = current counter.
  - mag < THRESH_LO: run = 0.
  - otherwise: run unchanged.
- Invalid cycles leave run unchanged.
- When the incremented run reaches CONFIRM_SAMPLES:
  - next cycle: echo_valid_out = 1 and echo_time_out = onset.
  - state returns to IDLE.
  - Latency is one cycle after the confirming sample.
- Timeout: in BLANK or LISTEN, when counter == TIMEOUT_CYCLES-1 and no confirmation occurs this cycle, pulse timeout_out next cycle and go to IDLE. echo_time_out is unchanged.
- Simultaneous confirmation and timeout in the same cycle: echo wins, no timeout pulse.
- echo_time_out holds its value until the next confirmation or reset.
- IDLE: samples are ignored; above_thresh_out still tracks valid samples in every state.
- echo_valid_out and timeout_out are never high together. Each is high for exactly one cycle per burst at most.

Decomposition:
- Shared package sonar_pkg holds:
  - state enum (IDLE, BLANK, LISTEN)
  - SAMPLE_WIDTH/TIME_WIDTH defaults
  - the default threshold constants, shared with top level and velocity logic.
- One sub-module, hysteresis_run_counter: magnitude + hysteresis + run counter + onset latch.
  - Inputs: clear, valid, sample, counter.
  - Outputs: confirm, onset, above.
- The parent holds the FSM, counter, and output registers.

Test Plan (BLANK_CYCLES=10, TIMEOUT_CYCLES=1000, THRESH_HI=5000, THRESH_LO=3000, CONFIRM_SAMPLES=3, samples valid every cycle):
- Reset: hold rst_n low, toggle inputs -> all outputs 0. Release; no activity without burst_start_in.
- Nominal echo: burst at counter 0; samples 6000 at counters 50, 51, 52, else 0 -> echo_valid_out one cycle after counter 52, echo_time_out = 50, busy_out falls, no timeout_out.
- Blanking/timeout: 8000 at counters 2–8 only -> ignored; timeout_out pulses after counter 999; echo_valid_out never asserts; echo_time_out keeps its prior value.
- Hysteresis:
  - Sequence 6000, 6000, 4000, -6000 from counter 100 -> confirm on -6000, echo_time_out = 100.
  - Repeat with 2000 instead of 4000 -> run cleared; confirmation needs 3 fresh samples and onset re-latches at 103.
- Re-arm/abort: run = 2 in LISTEN, then burst_start_in -> no pulse, busy_out stays 1, counter restarts at 0, samples ignored for 10 cycles.
- Edges:
  - sample -32768 counts as qualifying.
  - Confirming sample at counter 999 -> echo_valid_out only, no timeout.
  - Async rst_n low mid-LISTEN -> outputs 0 immediately without a clock edge.
